// File: rtl/tacho_multi.sv
// Multi-channel fan tachometer: synchronise and glitch-filter each tacho input,
// count rising edges over a one-second gate, latch saturating counts and raise
// stall/overflow flags with a maskable level interrupt, all exposed on a CSR bus.
module tacho_multi #(
  parameter logic [4:0]  BASE_ADDR  = 5'h0,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned CNT_WIDTH  = 12,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          csr_a,
  input  logic [7:0]          csr_di,
  input  logic                csr_we,
  output logic [7:0]          csr_do,
  input  logic                ce_1s,
  input  logic [CHANNELS-1:0] tacho_in,
  output logic                irq
);

  localparam int unsigned          NCH       = 4;
  localparam logic [3:0]           CH_MASK   = 4'((1 << CHANNELS) - 1);
  localparam logic [3:0]           FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  logic [3:0] ctrl_en, ctrl_ie, stall_flg, ovf_flg;
  logic [7:0] thresh;
  logic [3:0] tacho_pad, sync1, sync2, flt, flt_d, rise, ovf;
  logic [3:0] stall_set, ovf_set;
  logic [3:0]           fcnt [NCH];
  logic [CNT_WIDTH-1:0] live [NCH];
  logic [CNT_WIDTH-1:0] lat  [NCH];

  logic [5:0] diff;
  logic [4:0] off;
  logic       hit, wr_ctrl, wr_status, wr_thresh;
  logic [7:0] clr;

  assign tacho_pad = 4'(tacho_in);
  assign diff      = {1'b0, csr_a} - {1'b0, BASE_ADDR};
  assign off       = diff[4:0];
  assign hit       = !diff[5] && (off <= 5'd11);
  assign wr_ctrl   = csr_we && hit && (off == 5'd0);
  assign wr_status = csr_we && hit && (off == 5'd1);
  assign wr_thresh = csr_we && hit && (off == 5'd2);
  assign clr       = wr_status ? csr_di : 8'h00;

  // Per-channel flag set conditions evaluated at the gate pulse
  always_comb begin
    stall_set = '0;
    ovf_set   = '0;
    for (int i = 0; i < NCH; i++) begin
      stall_set[i] = ce_1s && ctrl_en[i] && (live[i] < CNT_WIDTH'(thresh));
      ovf_set[i]   = ce_1s && ovf[i];
    end
  end

  // Input synchronisers, glitch filters, edge detect, live and latched counters
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      flt   <= '0;
      flt_d <= '0;
      rise  <= '0;
      ovf   <= '0;
      for (int i = 0; i < NCH; i++) begin
        fcnt[i] <= '0;
        live[i] <= '0;
        lat[i]  <= '0;
      end
    end else begin
      sync1 <= tacho_pad;
      sync2 <= sync1;
      for (int i = 0; i < NCH; i++) begin
        if (!ctrl_en[i]) begin
          flt[i]   <= 1'b0;
          flt_d[i] <= 1'b0;
          rise[i]  <= 1'b0;
          ovf[i]   <= 1'b0;
          fcnt[i]  <= '0;
          live[i]  <= '0;
          if (ce_1s) lat[i] <= '0;
        end else begin
          flt_d[i] <= flt[i];
          rise[i]  <= flt[i] & ~flt_d[i];
          if (sync2[i] == flt[i]) begin
            fcnt[i] <= '0;
          end else if (fcnt[i] == FILT_LAST) begin
            flt[i]  <= ~flt[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + 4'd1;
          end
          // An edge coincident with the gate opens the new window at 1
          if (ce_1s) begin
            lat[i]  <= live[i];
            live[i] <= CNT_WIDTH'(rise[i]);
            ovf[i]  <= 1'b0;
          end else if (rise[i]) begin
            if (live[i] == CNT_MAX) ovf[i] <= 1'b1;
            else live[i] <= live[i] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  // CSR registers; status flags are write-1-to-clear with set priority
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_en   <= '0;
      ctrl_ie   <= '0;
      thresh    <= '0;
      stall_flg <= '0;
      ovf_flg   <= '0;
      irq       <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_en <= csr_di[3:0] & CH_MASK;
        ctrl_ie <= csr_di[7:4] & CH_MASK;
      end
      if (wr_thresh) thresh <= csr_di;
      stall_flg <= ((stall_flg & ~clr[3:0]) | stall_set) & CH_MASK;
      ovf_flg   <= ((ovf_flg & ~clr[7:4]) | ovf_set) & CH_MASK;
      irq       <= |(stall_flg & ctrl_ie);
    end
  end

  // Combinational read mux; count registers map two bytes per channel from +4
  always_comb begin
    logic [1:0] ch;
    ch     = off[2:1] - 2'd2;
    csr_do = 8'h00;
    if (hit) begin
      case (off)
        5'd0:    csr_do = {ctrl_ie, ctrl_en};
        5'd1:    csr_do = {ovf_flg, stall_flg};
        5'd2:    csr_do = thresh;
        5'd3:    csr_do = 8'h00;
        default: csr_do = off[0] ? 8'(lat[ch] >> 8) : lat[ch][7:0];
      endcase
    end
  end

endmodule

// File: tb/tb_tacho_multi.sv
// Directed bench for tacho_multi: a 2-channel 12-bit instance at base 0 and a
// 1-channel 8-bit instance at base 20 share the CSR bus and the gate pulse.
module tb_tacho_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic       ce_1s;
  logic [1:0] t1;
  logic [0:0] t2;
  logic [7:0] csr_do1, csr_do2;
  logic       irq1, irq2;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [4:0] a;
    logic [7:0] exp;
    string      nm;
  } rd_vec_t;

  rd_vec_t tbl[$];

  always #5 clk = ~clk;

  tacho_multi #(.BASE_ADDR(5'd0), .CHANNELS(2), .CNT_WIDTH(12), .FILTER_LEN(4)) u1 (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(csr_do1), .ce_1s(ce_1s), .tacho_in(t1), .irq(irq1)
  );

  tacho_multi #(.BASE_ADDR(5'd20), .CHANNELS(1), .CNT_WIDTH(8), .FILTER_LEN(4)) u2 (
    .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
    .csr_do(csr_do2), .ce_1s(ce_1s), .tacho_in(t2), .irq(irq2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
  endtask

  // Unaddressed instance drives 0, so OR of both read ports is the bus value
  task automatic rd(input logic [4:0] addr, input logic [7:0] exp, input string nm);
    csr_a = addr;
    #1;
    chk(nm, csr_do1 | csr_do2, exp);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [7:0] data);
    csr_a  = addr;
    csr_di = data;
    csr_we = 1'b1;
    tick();
    csr_we = 1'b0;
  endtask

  task automatic gate();
    ce_1s = 1'b1;
    tick();
    ce_1s = 1'b0;
  endtask

  task automatic pulse1(input int ch, input int hi, input int lo);
    t1[ch] = 1'b1;
    repeat (hi) tick();
    t1[ch] = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic pulse2(input int hi, input int lo);
    t2[0] = 1'b1;
    repeat (hi) tick();
    t2[0] = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) rd(tbl[i].a, tbl[i].exp, tbl[i].nm);
    tbl.delete();
  endtask

  initial begin
    rst = 1'b1; ce_1s = 1'b0; csr_we = 1'b0; csr_a = '0; csr_di = '0;
    t1 = '0; t2 = '0;
    repeat (2) tick();
    gate();
    tick();
    rst = 1'b0;
    tick();

    // Reset state: every register of both instances reads 0
    for (int a = 0; a < 12; a++) rd(5'(a), 8'h00, "reset_u1");
    for (int a = 20; a < 32; a++) rd(5'(a), 8'h00, "reset_u2");
    chk("reset_irq1", {7'b0, irq1}, 8'h00);
    chk("reset_irq2", {7'b0, irq2}, 8'h00);

    // Clean counting on two channels
    wr(5'd0, 8'h03);
    wr(5'd2, 8'h00);
    for (int k = 0; k < 100; k++) pulse1(0, 8, 8);
    for (int k = 0; k < 37; k++) pulse1(1, 8, 8);
    repeat (12) tick();
    rd(5'd4, 8'h00, "no_update_before_gate");
    gate();
    tbl.push_back('{5'd4,  8'h64, "ch0_lo"});
    tbl.push_back('{5'd5,  8'h00, "ch0_hi"});
    tbl.push_back('{5'd6,  8'h25, "ch1_lo"});
    tbl.push_back('{5'd7,  8'h00, "ch1_hi"});
    tbl.push_back('{5'd1,  8'h00, "status_clean"});
    tbl.push_back('{5'd3,  8'h00, "reserved"});
    tbl.push_back('{5'd8,  8'h00, "ch2_absent_lo"});
    tbl.push_back('{5'd11, 8'h00, "ch3_absent_hi"});
    tbl.push_back('{5'd12, 8'h00, "unmapped"});
    tbl.push_back('{5'd0,  8'h03, "ctrl_rb"});
    run_tbl();
    wr(5'd0, 8'hFF);
    rd(5'd0, 8'h33, "ctrl_masked");
    wr(5'd0, 8'h03);

    // Glitch rejection: short highs, one short low dip, five real pulses
    pulse1(0, 1, 8);
    pulse1(0, 2, 8);
    pulse1(0, 3, 8);
    pulse1(0, 8, 8);
    pulse1(0, 8, 8);
    pulse1(0, 4, 2);
    pulse1(0, 4, 8);
    pulse1(0, 8, 8);
    pulse1(0, 8, 8);
    repeat (12) tick();
    gate();
    rd(5'd4, 8'h05, "glitch_ch0_lo");
    rd(5'd6, 8'h00, "glitch_ch1_lo");

    // Saturation and overflow on the 8-bit instance
    wr(5'd20, 8'h01);
    for (int k = 0; k < 300; k++) pulse2(6, 6);
    repeat (12) tick();
    gate();
    tbl.push_back('{5'd24, 8'hFF, "sat_lo"});
    tbl.push_back('{5'd25, 8'h00, "sat_hi_w8"});
    tbl.push_back('{5'd21, 8'h10, "ovf_flag"});
    tbl.push_back('{5'd26, 8'h00, "u2_ch1_absent"});
    run_tbl();
    chk("u2_irq_masked", {7'b0, irq2}, 8'h00);
    wr(5'd21, 8'h10);
    rd(5'd21, 8'h00, "ovf_cleared");

    // Stall flag and interrupt timing
    wr(5'd2, 8'd10);
    wr(5'd0, 8'h11);
    for (int k = 0; k < 3; k++) pulse1(0, 8, 8);
    repeat (12) tick();
    gate();
    rd(5'd1, 8'h01, "stall_set");
    rd(5'd4, 8'h03, "stall_count");
    chk("irq_not_yet", {7'b0, irq1}, 8'h00);
    tick();
    chk("irq_asserted", {7'b0, irq1}, 8'h01);
    wr(5'd1, 8'h01);
    rd(5'd1, 8'h00, "stall_cleared");
    chk("irq_still_high", {7'b0, irq1}, 8'h01);
    tick();
    chk("irq_deasserted", {7'b0, irq1}, 8'h00);

    // Clearing write coincident with the gate: the set wins
    for (int k = 0; k < 3; k++) pulse1(0, 8, 8);
    repeat (12) tick();
    csr_a = 5'd1; csr_di = 8'h01; csr_we = 1'b1; ce_1s = 1'b1;
    tick();
    csr_we = 1'b0; ce_1s = 1'b0;
    rd(5'd1, 8'h01, "set_wins");
    tick();
    chk("irq_set_wins", {7'b0, irq1}, 8'h01);
    wr(5'd1, 8'h01);
    tick();
    chk("irq_final_clear", {7'b0, irq1}, 8'h00);

    // Rising edge coincident with the gate belongs to the new window
    wr(5'd2, 8'h00);
    wr(5'd0, 8'h01);
    gate();
    wr(5'd1, 8'hFF);
    pulse1(0, 8, 8);
    pulse1(0, 8, 8);
    repeat (12) tick();
    t1[0] = 1'b1;
    repeat (7) tick();
    gate();
    rd(5'd4, 8'h02, "coincident_old_window");
    repeat (8) tick();
    t1[0] = 1'b0;
    repeat (12) tick();
    gate();
    rd(5'd4, 8'h01, "coincident_new_window");
    rd(5'd1, 8'h00, "no_flags_thresh0");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
